// File: rtl/pc_adder_pkg.sv
// rtl/pc_adder_pkg.sv - shared width, PC type and default step for the 3-bit PC adder
package pc_adder_pkg;
  localparam int unsigned PC_W = 3;
  localparam int unsigned STEP_DEFAULT = 1;

  typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/pc_adder_3bit_if.sv
// rtl/pc_adder_3bit_if.sv - PC adder data/control bundle with master (driver) and slave (adder) views
interface pc_adder_3bit_if;
  import pc_adder_pkg::*;

  pc_t  i;
  pc_t  o;
  pc_t  pc;
  logic ld;
  logic en;
  logic wrap;
  logic co;

  modport master (output i, ld, en, input  o, pc, wrap, co);
  modport slave  (input  i, ld, en, output o, pc, wrap, co);
endinterface

// File: rtl/pc_inc.sv
// rtl/pc_inc.sv - combinational 3-bit unsigned adder with carry out
module pc_inc
  import pc_adder_pkg::*;
(
  input  pc_t  a,
  input  pc_t  step,
  output pc_t  sum,
  output logic carry
);
  logic [PC_W:0] full;

  assign full  = {1'b0, a} + {1'b0, step};
  assign sum   = full[PC_W-1:0];
  assign carry = full[PC_W];
endmodule

// File: rtl/pc_adder_3bit.sv
// rtl/pc_adder_3bit.sv - next-PC adder plus loadable registered PC with wrap pulse
// Optional feature macro: PC_ADDER_CARRY_EN (drives co from the adder carry; otherwise co is 0)
module pc_adder_3bit
  import pc_adder_pkg::*;
#(
  parameter int unsigned STEP = STEP_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  pc_adder_3bit_if.slave   bus
);
  localparam pc_t STEP_T = pc_t'(STEP);

  pc_t  pc_q, pc_d, pc_sum;
  logic wrap_q, wrap_d, pc_carry;
  logic run_q;
  logic o_carry;

  pc_inc u_o_inc (
    .a     (bus.i),
    .step  (STEP_T),
    .sum   (bus.o),
    .carry (o_carry)
  );

  pc_inc u_pc_inc (
    .a     (pc_q),
    .step  (STEP_T),
    .sum   (pc_sum),
    .carry (pc_carry)
  );

`ifdef PC_ADDER_CARRY_EN
  assign bus.co = o_carry;
`else
  assign bus.co = o_carry & 1'b0;
`endif

  // run_q gates updates so the first edge after reset release only arms the register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      pc_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (run_q) begin
      if (bus.ld) begin
        pc_d = bus.i;
      end else if (bus.en) begin
        pc_d   = pc_sum;
        wrap_d = pc_carry;
      end
    end
  end

  assign bus.pc   = pc_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_pc_adder_3bit.sv
// tb/tb_pc_adder_3bit.sv - directed-vector bench for pc_adder_3bit (STEP=1 and STEP=3 instances)
module tb_pc_adder_3bit;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pc_adder_3bit_if bus1 ();
  pc_adder_3bit_if bus3 ();

  pc_adder_3bit #(.STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pc_adder_3bit #(.STEP(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

`ifdef PC_ADDER_CARRY_EN
  localparam logic CO_ON = 1'b1;
`else
  localparam logic CO_ON = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_pc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus1.i = 3'b000; bus1.ld = 1'b0; bus1.en = 1'b0;
    bus3.i = 3'b000; bus3.ld = 1'b0; bus3.en = 1'b0;

    #2;
    check("reset_pc", {5'd0, bus1.pc}, 8'd0);
    check("reset_wrap", {7'd0, bus1.wrap}, 8'd0);

    // combinational next-PC, exercised while rst is still held
    bus1.i = 3'b000; #20;
    check("o_000", {5'd0, bus1.o}, 8'd1);
    check("co_000", {7'd0, bus1.co}, 8'd0);
    bus1.i = 3'b101; #20;
    check("o_101", {5'd0, bus1.o}, 8'd6);
    check("co_101", {7'd0, bus1.co}, 8'd0);
    bus1.i = 3'b111; #20;
    check("o_111", {5'd0, bus1.o}, 8'd0);
    check("co_111", {7'd0, bus1.co}, {7'd0, CO_ON});

    // release reset with en high: first edge only arms, then counting starts
    tick();
    rst = 1'b0;
    bus1.en = 1'b1;
    tick();
    check("sync_first_edge_pc", {5'd0, bus1.pc}, 8'd0);
    exp_pc = 3'd0;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_pc = exp_pc + 3'd1;
      check("count_pc", {5'd0, bus1.pc}, {5'd0, exp_pc});
      check("count_wrap", {7'd0, bus1.wrap}, (exp_pc == 3'd0) ? 8'd1 : 8'd0);
    end

    bus1.en = 1'b0;
    tick();
    check("hold_pc", {5'd0, bus1.pc}, 8'd1);
    check("hold_wrap", {7'd0, bus1.wrap}, 8'd0);

    bus1.ld = 1'b1; bus1.i = 3'b011;
    tick();
    check("load_pc", {5'd0, bus1.pc}, 8'd3);
    bus1.en = 1'b1; bus1.i = 3'b110;
    tick();
    check("ld_over_en_pc", {5'd0, bus1.pc}, 8'd6);
    check("ld_over_en_wrap", {7'd0, bus1.wrap}, 8'd0);

    // load 111 then en-wrap: ld from 111 must not pulse wrap
    bus1.i = 3'b111;
    tick();
    check("ld_111_wrap", {7'd0, bus1.wrap}, 8'd0);
    bus1.ld = 1'b0;
    tick();
    check("wrap_pc", {5'd0, bus1.pc}, 8'd0);
    check("wrap_pulse", {7'd0, bus1.wrap}, 8'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_clears_wrap", {7'd0, bus1.wrap}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    // mid-cycle reset from pc=101 with en pending
    bus1.ld = 1'b1; bus1.en = 1'b0; bus1.i = 3'b101;
    tick();
    check("ld_101", {5'd0, bus1.pc}, 8'd5);
    bus1.ld = 1'b0; bus1.en = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("async_rst_pc", {5'd0, bus1.pc}, 8'd0);
    check("async_rst_wrap", {7'd0, bus1.wrap}, 8'd0);
    check("rst_o_unaffected", {5'd0, bus1.o}, 8'd6);
    tick();
    check("rst_held_pc", {5'd0, bus1.pc}, 8'd0);
    rst = 1'b0;
    tick();
    check("release_edge1_pc", {5'd0, bus1.pc}, 8'd0);
    tick();
    check("release_edge2_pc", {5'd0, bus1.pc}, 8'd1);
    bus1.en = 1'b0;

    // STEP=3 instance
    bus3.i = 3'b110; #1;
    check("s3_o_110", {5'd0, bus3.o}, 8'd1);
    check("s3_co_110", {7'd0, bus3.co}, {7'd0, CO_ON});
    bus3.i = 3'b010; #1;
    check("s3_o_010", {5'd0, bus3.o}, 8'd5);
    check("s3_co_010", {7'd0, bus3.co}, 8'd0);
    bus3.i = 3'b110; bus3.ld = 1'b1;
    tick();
    check("s3_ld_pc", {5'd0, bus3.pc}, 8'd6);
    bus3.ld = 1'b0; bus3.en = 1'b1;
    tick();
    check("s3_en_pc", {5'd0, bus3.pc}, 8'd1);
    check("s3_en_wrap", {7'd0, bus3.wrap}, 8'd1);
    tick();
    check("s3_en2_pc", {5'd0, bus3.pc}, 8'd4);
    check("s3_en2_wrap", {7'd0, bus3.wrap}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_adder_3bit.md
PC_ADDER_3BIT -- requirements
Module: pc_adder_3bit

Interface
- REQ-001 Parameter STEP, default 1: increment amount, range 1..7; the value is truncated to 3 bits.
- REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003 rst  input  1  reset, asynchronous, active-high.
- REQ-004 i  input  3  PC value to increment; also the load value for the internal PC.
- REQ-005 o  output  3  combinational next-PC: i + STEP, modulo 8.
- REQ-006 ld  input  1  load request: the internal PC takes the value i.
- REQ-007 en  input  1  advance request: the internal PC increments by STEP.
- REQ-008 pc  output  3  registered internal PC value.
- REQ-009 wrap  output  1  registered single-cycle pulse when the internal PC wraps past 7.
- REQ-010 co  output  1  combinational carry out of i + STEP (see Configuration).

Function
- REQ-011 o SHALL equal (i + STEP) mod 8 with zero clock latency, independent of clk, rst, ld and en.
- REQ-012 With STEP=1, o SHALL map i as follows: 000->001, 101->110, 111->000 (wrap-around, no saturation).
- REQ-013 On a rising clk edge with ld=1, pc SHALL take i; ld has priority over en.
- REQ-014 On a rising clk edge with ld=0 and en=1, pc SHALL take (pc + STEP) mod 8.
- REQ-015 On a rising clk edge with ld=0 and en=0, pc SHALL hold.
- REQ-016 wrap SHALL be 1 for exactly one cycle after an en-driven increment whose true sum exceeds 7; otherwise wrap is 0, including after every ld cycle.
- REQ-017 All arithmetic SHALL be unsigned, 3 bits wide; carries beyond bit 2 are discarded except as described for co and wrap.
- REQ-018 X on i SHALL propagate only to o and co, and to pc when ld=1.

Reset
- REQ-019 While rst=1, pc SHALL be 000 and wrap SHALL be 0, immediately and without waiting for clk.
- REQ-020 Reset deassertion SHALL be synchronized internally, so that the first update occurs on the second clk edge after rst falls.
- REQ-021 Reset asserted mid-operation SHALL override any ld or en in progress.
- REQ-022 o and co are combinational and SHALL NOT be affected by rst.

Configuration
- REQ-023 Macro PC_ADDER_CARRY_EN defined: co SHALL equal the carry out of i + STEP, i.e. 1 when i + STEP > 7.
- REQ-024 Macro PC_ADDER_CARRY_EN undefined: co SHALL be tied to 0; all other behaviour is unchanged.

Structure
- REQ-025 Shared package pc_adder_pkg SHALL hold the constant PC_W=3, the typedef pc_t (3-bit unsigned) and the default STEP value.
- REQ-026 Sub-module pc_inc SHALL be the combinational adder (inputs a, step; outputs sum, carry).
- REQ-027 pc_inc SHALL be instantiated twice: once for the o/co path and once for the pc register path.

Verification
- REQ-028 STEP=1, i=000, then 101, then 111, 20 ns apart -> o=001, then 110, then 000; co=0, 0, 1 when PC_ADDER_CARRY_EN is defined, and co=0 throughout when it is undefined.
- REQ-029 Reset, then en=1 for 9 cycles -> pc=001..111, 000, 001; wrap=1 only in the cycle where pc=000.
- REQ-030 pc=011, ld=1 and en=1 together with i=110 -> pc=110, wrap=0.
- REQ-031 pc=101 with en=1, assert rst between clock edges -> pc=000 and wrap=0 immediately; no increment until the second edge after release.
- REQ-032 STEP=3, i=110 -> o=001, co=1 (macro defined); en from pc=110 -> pc=001, wrap=1.
